// File: rtl/alu_seq_pkg.sv
// Shared constants and state encoding for the byte-sliced ALU operation sequencer.
package alu_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Runs one 8-bit or 16-bit operation through an external 8-bit ALU slice,
// low byte first, chaining the slice carry into the high byte.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic                ReqMode,
  input  logic [3:0]          ReqSelector,
  input  logic                ReqCarryIn,
  input  logic [DATA_W-1:0]   ReqA,
  input  logic [DATA_W-1:0]   ReqB,
  input  logic                ReqWide,
  output logic                AluMode,
  output logic [3:0]          AluSelector,
  output logic [BYTE_W-1:0]   AluA,
  output logic [BYTE_W-1:0]   AluB,
  output logic                AluCarryIn,
  input  logic [BYTE_W-1:0]   AluF,
  input  logic                AluCarryOut,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [DATA_W-1:0]   RspF,
  output logic                RspCarryOut,
  output logic                RspZero
);

  state_e                    state_q, state_d;
  logic                      wide_q;
  logic [DATA_W-BYTE_W-1:0]  aHigh_q, bHigh_q;
  logic                      carry_q;
  logic                      aluMode_q;
  logic [3:0]                aluSel_q;
  logic [BYTE_W-1:0]         aluA_q, aluB_q;
  logic                      aluCin_q;
  logic [DATA_W-1:0]         rspF_q;
  logic                      rspZero_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ReqValid) state_d = ST_LOW;
      ST_LOW:  state_d = wide_q ? ST_HIGH : ST_DONE;
      ST_HIGH: state_d = ST_DONE;
      ST_DONE: if (RspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // carry_q holds the low-slice carry after LOW and the final carry after HIGH.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ST_IDLE;
      wide_q    <= 1'b0;
      aHigh_q   <= '0;
      bHigh_q   <= '0;
      carry_q   <= 1'b0;
      aluMode_q <= 1'b0;
      aluSel_q  <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluCin_q  <= 1'b0;
      rspF_q    <= '0;
      rspZero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (ReqValid) begin
            wide_q    <= ReqWide;
            aHigh_q   <= ReqA[DATA_W-1:BYTE_W];
            bHigh_q   <= ReqB[DATA_W-1:BYTE_W];
            aluMode_q <= ReqMode;
            aluSel_q  <= ReqSelector;
            aluA_q    <= ReqA[BYTE_W-1:0];
            aluB_q    <= ReqB[BYTE_W-1:0];
            aluCin_q  <= ReqCarryIn;
          end
        end
        ST_LOW: begin
          rspF_q    <= {{(DATA_W-BYTE_W){1'b0}}, AluF};
          carry_q   <= AluCarryOut;
          rspZero_q <= (AluF == '0);
          if (wide_q) begin
            aluA_q   <= aHigh_q;
            aluB_q   <= bHigh_q;
            aluCin_q <= AluCarryOut;
          end
        end
        ST_HIGH: begin
          rspF_q[DATA_W-1:BYTE_W] <= AluF;
          carry_q                 <= AluCarryOut;
          rspZero_q               <= (AluF == '0) && (rspF_q[BYTE_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

  assign ReqReady    = (state_q == ST_IDLE);
  assign RspValid    = (state_q == ST_DONE);
  assign RspF        = rspF_q;
  assign RspCarryOut = carry_q;
  assign RspZero     = rspZero_q;
  assign AluMode     = aluMode_q;
  assign AluSelector = aluSel_q;
  assign AluA        = aluA_q;
  assign AluB        = aluB_q;
  assign AluCarryIn  = aluCin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder standing in for the ALU slice.
module tb_alu_op_sequencer;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        ReqValid, ReqReady, ReqMode, ReqCarryIn, ReqWide;
  logic [3:0]  ReqSelector;
  logic [15:0] ReqA, ReqB;
  logic        AluMode, AluCarryIn, AluCarryOut;
  logic [3:0]  AluSelector;
  logic [7:0]  AluA, AluB, AluF;
  logic        RspValid, RspReady, RspCarryOut, RspZero;
  logic [15:0] RspF;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        wide;
    logic [15:0] expF;
    logic        expC;
    logic        expZ;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  always #5 Clock = ~Clock;

  assign {AluCarryOut, AluF} = {1'b0, AluA} + {1'b0, AluB} + {8'b0, AluCarryIn};

  alu_op_sequencer #(.DATA_W(16)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqMode(ReqMode), .ReqSelector(ReqSelector), .ReqCarryIn(ReqCarryIn),
    .ReqA(ReqA), .ReqB(ReqB), .ReqWide(ReqWide),
    .AluMode(AluMode), .AluSelector(AluSelector), .AluA(AluA), .AluB(AluB),
    .AluCarryIn(AluCarryIn), .AluF(AluF), .AluCarryOut(AluCarryOut),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspF(RspF), .RspCarryOut(RspCarryOut), .RspZero(RspZero)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rsp zero"}, {13'b0, RspValid, RspF, RspCarryOut, RspZero}, 32'h0);
    checkOutput({tag, " alu zero"}, {9'b0, AluMode, AluSelector, AluA, AluB, AluCarryIn}, 32'h0);
  endtask

  // Drives one request, counts edges from the accept edge (counted as 1) to RspValid,
  // then checks the result and the handshake back to IDLE (RspReady assumed high).
  task automatic applyStimulus(input vec_t v, input logic mode, input logic [3:0] sel, input string tag);
    int lat;
    @(negedge Clock);
    checkOutput({tag, " ReqReady idle"}, ReqReady, 1);
    ReqValid = 1'b1; ReqA = v.a; ReqB = v.b; ReqCarryIn = v.cin; ReqWide = v.wide;
    ReqMode = mode; ReqSelector = sel;
    @(posedge Clock); #1;
    ReqValid = 1'b0; ReqA = 16'hDEAD; ReqB = 16'hBEEF; ReqWide = ~v.wide; ReqMode = ~mode;
    lat = 1;
    while (!RspValid && lat < 8) begin
      checkOutput({tag, " ReqReady busy"}, ReqReady, 0);
      @(posedge Clock); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, v.expLat);
    checkOutput({tag, " RspF"}, RspF, v.expF);
    checkOutput({tag, " RspCarryOut"}, RspCarryOut, v.expC);
    checkOutput({tag, " RspZero"}, RspZero, v.expZ);
    checkOutput({tag, " AluMode held"}, AluMode, mode);
    checkOutput({tag, " AluSelector held"}, AluSelector, sel);
    checkOutput({tag, " AluA held"}, AluA, v.wide ? v.a[15:8] : v.a[7:0]);
    @(posedge Clock); #1;
    checkOutput({tag, " RspValid after hs"}, RspValid, 0);
    checkOutput({tag, " ReqReady after hs"}, ReqReady, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{16'h12FF, 16'h0001, 1'b0, 1'b1, 16'h1300, 1'b0, 1'b0, 3};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 3};
    vecs[2] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, 1'b0, 3};
    vecs[4] = '{16'hAB80, 16'hCD80, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 3};
    vecs[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
    vecs[7] = '{16'h7F7F, 16'h0101, 1'b0, 1'b1, 16'h8080, 1'b0, 1'b0, 3};
    vecs[8] = '{16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 2};
    vecs[9] = '{16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 3};

    ResetN = 1'b0; ReqValid = 1'b0; ReqMode = 1'b0; ReqSelector = 4'h0; ReqCarryIn = 1'b0;
    ReqA = 16'h0; ReqB = 16'h0; ReqWide = 1'b0; RspReady = 1'b1;
    repeat (2) @(negedge Clock);
    checkAllZero("reset");
    ResetN = 1'b1;
    @(posedge Clock); #1;
    checkOutput("ReqReady after reset", ReqReady, 1);

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i], i[0], 4'(i + 3), $sformatf("vec%0d", i));

    // Result must hold while RspReady is low; a pending request waits for IDLE.
    RspReady = 1'b0;
    @(negedge Clock);
    ReqValid = 1'b1; ReqA = 16'h0102; ReqB = 16'h0304; ReqCarryIn = 1'b0; ReqWide = 1'b1;
    ReqMode = 1'b0; ReqSelector = 4'h9;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (!RspValid && lat < 8) begin
      @(posedge Clock); #1;
      lat++;
    end
    checkOutput("hold latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      ReqValid = 1'b1; ReqA = 16'h5555; ReqB = 16'h1111; ReqWide = 1'b0;
      @(posedge Clock); #1;
      checkOutput("hold RspValid", RspValid, 1);
      checkOutput("hold RspF", RspF, 16'h0406);
      checkOutput("hold RspZero", RspZero, 0);
      checkOutput("hold ReqReady", ReqReady, 0);
      checkOutput("hold AluA", AluA, 8'h01);
    end
    @(negedge Clock);
    RspReady = 1'b1;
    @(posedge Clock); #1;
    checkOutput("hold hs RspValid", RspValid, 0);
    checkOutput("hold hs ReqReady", ReqReady, 1);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    checkOutput("next accepted ReqReady", ReqReady, 0);
    checkOutput("next accepted AluA", AluA, 8'h55);
    lat = 1;
    while (!RspValid && lat < 8) begin
      @(posedge Clock); #1;
      lat++;
    end
    checkOutput("next latency", lat, 2);
    checkOutput("next RspF", RspF, 16'h0066);
    checkOutput("next RspCarryOut", RspCarryOut, 0);
    @(posedge Clock); #1;

    // Reset in HIGH must drop the operation without any response.
    @(negedge Clock);
    ReqValid = 1'b1; ReqA = 16'h12FF; ReqB = 16'h0001; ReqCarryIn = 1'b0; ReqWide = 1'b1;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    @(posedge Clock); #1;
    checkOutput("high AluA", AluA, 8'h12);
    checkOutput("high AluCarryIn chained", AluCarryIn, 1);
    #2 ResetN = 1'b0;
    #1 checkAllZero("midop reset");
    @(negedge Clock);
    ResetN = 1'b1;
    checkOutput("ReqReady after midop reset", ReqReady, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      checkOutput("no RspValid after abort", RspValid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
